// File: rtl/ram_pingpong_array.sv
// ram_pingpong_array: NUM_BLOCKS parallel pixel RAMs for the LED block drivers.
// The writer fills the back bank while the driver side reads the front bank
// column by column. Banks swap on a driver SOF once the writer has flagged the
// back bank complete with frame_done.
// Optional feature macro: RAM_PINGPONG_DOUBLE_BUFFER_EN
//   defined   -> two banks per block, swap FSM, overrun flag
//   undefined -> one bank per block, writes land in the displayed bank

// Simple dual-port RAM, one per block. Registered read, no reset on contents.
module ram_pingpong_array_ram #(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [2**AW];

    // Write port and registered read port; the banks differ, so no collision
    // in the double-buffered build.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) q <= mem[raddr];
    end
endmodule

module ram_pingpong_array #(
    parameter int NUM_BLOCKS = 15,
    parameter int PIXELS     = 128,
    parameter int DATA_WIDTH = 24,
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
    localparam int AW = $clog2(PIXELS)
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic                                   clk_enable,
    input  logic [BW-1:0]                          block_number,
    input  logic [AW-1:0]                          pixel_number,
    input  logic [DATA_WIDTH-1:0]                  ram_data,
    input  logic                                   block_write_enable,
    input  logic                                   frame_done,
    input  logic                                   SOF,
    input  logic                                   EOC,
    output logic [NUM_BLOCKS-1:0][DATA_WIDTH-1:0]  data_out,
    output logic                                   data_valid,
    output logic                                   drivers_SOF,
    output logic                                   front_sel,
    output logic                                   overrun
);
`ifdef RAM_PINGPONG_DOUBLE_BUFFER_EN
    localparam int RW = AW + 1;
`else
    localparam int RW = AW;
`endif

    logic                                  sof_q, eoc_q, rd_ev;
    logic [AW-1:0]                         rd_addr;
    logic [1:0]                            vld_pipe, sof_pipe;
    logic [RW-1:0]                         wr_ram_addr, rd_ram_addr;
    logic [NUM_BLOCKS-1:0][DATA_WIDTH-1:0] ram_q;

    assign sof_q = SOF & clk_enable;
    assign eoc_q = EOC & clk_enable;
    assign rd_ev = sof_q | eoc_q;

`ifdef RAM_PINGPONG_DOUBLE_BUFFER_EN
    // Writes always target the back bank as seen before any swap this cycle.
    assign wr_ram_addr = {~front_sel, pixel_number};
    assign rd_ram_addr = {front_sel, rd_addr};

    typedef enum logic {IDLE, PENDING} swap_state_t;
    swap_state_t state;

    // Swap FSM: frame_done arms a swap, the next qualified SOF performs it.
    // A frame_done coinciding with SOF only arms; it never swaps that cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (frame_done) state <= PENDING;
                PENDING: begin
                    if (frame_done) begin
                        overrun <= 1'b1;
                    end else if (sof_q) begin
                        front_sel <= ~front_sel;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
    assign wr_ram_addr = pixel_number;
    assign rd_ram_addr = rd_addr;
    assign front_sel   = 1'b0;
    assign overrun     = 1'b0;
`endif

    // One RAM per block; only indices below NUM_BLOCKS exist, so an
    // out-of-range block_number matches no instance and the write is dropped.
    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
        ram_pingpong_array_ram #(.AW(RW), .DW(DATA_WIDTH)) u_ram (
            .clk   (clk),
            .we    (block_write_enable && (block_number == BW'(i))),
            .waddr (wr_ram_addr),
            .wdata (ram_data),
            .re    (vld_pipe[0]),
            .raddr (rd_ram_addr),
            .q     (ram_q[i])
        );
    end

    // Read address and valid pipeline. SOF wins over EOC; the pipeline
    // drains in-flight reads even while clk_enable is low.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_addr  <= '0;
            vld_pipe <= '0;
            sof_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], rd_ev};
            sof_pipe <= {sof_pipe[0], sof_q};
            if (sof_q)      rd_addr <= '0;
            else if (eoc_q) rd_addr <= rd_addr + AW'(1);
        end
    end

    // Output register: data, valid and SOF marker two edges after the event.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            drivers_SOF <= 1'b0;
        end else begin
            data_valid  <= vld_pipe[1];
            drivers_SOF <= sof_pipe[1];
            if (vld_pipe[1]) data_out <= ram_q;
        end
    end
endmodule

// File: tb/tb_ram_pingpong_array.sv
// Scoreboard bench for ram_pingpong_array: a behavioural model of banks,
// swap rule and read pointer predicts every read-out word; a monitor checks
// them as data_valid appears.
module tb_ram_pingpong_array;
    localparam int NB = 15;
    localparam int PX = 16;
    localparam int DW = 24;
    localparam int BW = 4;
    localparam int AW = 4;
`ifdef RAM_PINGPONG_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    nrst;
    logic                    clk_enable;
    logic [BW-1:0]           block_number;
    logic [AW-1:0]           pixel_number;
    logic [DW-1:0]           ram_data;
    logic                    block_write_enable;
    logic                    frame_done;
    logic                    SOF;
    logic                    EOC;
    logic [NB-1:0][DW-1:0]   data_out;
    logic                    data_valid;
    logic                    drivers_SOF;
    logic                    front_sel;
    logic                    overrun;

    ram_pingpong_array #(.NUM_BLOCKS(NB), .PIXELS(PX), .DATA_WIDTH(DW)) dut (
        .clk(clk), .nrst(nrst), .clk_enable(clk_enable),
        .block_number(block_number), .pixel_number(pixel_number),
        .ram_data(ram_data), .block_write_enable(block_write_enable),
        .frame_done(frame_done), .SOF(SOF), .EOC(EOC),
        .data_out(data_out), .data_valid(data_valid),
        .drivers_SOF(drivers_SOF), .front_sel(front_sel), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0][DW-1:0] d;
        bit                    sof;
        int                    due;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: whole frame buffers, display bank, armed flag, column.
    logic [DW-1:0] mem_m [NB][2][PX];
    bit m_front, m_pend, m_ovr;
    int m_rd;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int b, input int p);
        logic [7:0]  bb = 8'(b);
        logic [15:0] pp = 16'(p);
        return {bb, pp};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_front = 0; m_pend = 0; m_ovr = 0; m_rd = 0;
        q.delete();
    endtask

    // Drive one cycle, predict its effect, then check the flags after the edge.
    task automatic step(input bit we, input int blk, input int pix, input logic [DW-1:0] d,
                        input bit fd, input bit sof, input bit eoc, input bit ce);
        exp_t e;
        block_write_enable = we; block_number = blk[BW-1:0]; pixel_number = pix[AW-1:0];
        ram_data = d; frame_done = fd; SOF = sof; EOC = eoc; clk_enable = ce;
        if (we && blk < NB) mem_m[blk][DB & ~m_front][pix] = d;
        if (DB) begin
            if (fd) begin
                if (m_pend) m_ovr = 1;
                m_pend = 1;
            end else if (m_pend && sof && ce) begin
                m_front = ~m_front;
                m_pend = 0;
            end
        end
        if (ce && (sof || eoc)) begin
            m_rd = sof ? 0 : (m_rd + 1) % PX;
            for (int b = 0; b < NB; b++) e.d[b] = mem_m[b][m_front][m_rd];
            e.sof = sof;
            e.due = cyc + 3;
            q.push_back(e);
        end
        @(posedge clk); #1;
        chk("front_sel", 64'(front_sel), 64'(m_front));
        chk("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0, 0, 1);
    endtask

    // Monitor: pop and compare whenever the DUT presents a word.
    always @(negedge clk) begin
        exp_t e;
        if (nrst) begin
            if (!data_valid && drivers_SOF) begin
                tests++; fails++;
                $display("FAIL drivers_SOF_without_valid at cycle %0d", cyc);
            end
            if (data_valid) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    if (data_out !== e.d || drivers_SOF !== e.sof || cyc != e.due) begin
                        fails++;
                        $display("FAIL readout cycle %0d (due %0d): data %h sof %0b, expected %h sof %0b",
                                 cyc, e.due, data_out, drivers_SOF, e.d, e.sof);
                    end
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                tests++; fails++;
                e = q.pop_front();
                $display("FAIL missing_valid at cycle %0d (due %0d) got valid 0 expected 1", cyc, e.due);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_valid"}, 64'(data_valid), 64'd0);
        chk({tag, "_drivers_SOF"}, 64'(drivers_SOF), 64'd0);
        chk({tag, "_front_sel"}, 64'(front_sel), 64'd0);
        chk({tag, "_overrun"}, 64'(overrun), 64'd0);
        tests++;
        if (data_out !== '0) begin
            fails++;
            $display("FAIL %s_data_out: got %h expected 0", tag, data_out);
        end
    endtask

    initial begin
        nrst = 0; clk_enable = 0; block_number = '0; pixel_number = '0; ram_data = '0;
        block_write_enable = 0; frame_done = 0; SOF = 0; EOC = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        nrst = 1;

        // Basic read-out: pattern into back bank, arm, swap, then walk columns.
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < PX; p++) step(1, b, p, pat(b, p), 0, 0, 0, 1);
        step(0, 0, 0, '0, 1, 0, 0, 1);
        step(0, 0, 0, '0, 0, 1, 0, 1);
        // Wrap-around: PX EOCs reach PX-1 then pixel 0.
        for (int i = 0; i < PX + 1; i++) step(0, 0, 0, '0, 0, 0, 1, 1);
        idle(); idle();

        // Back-bank isolation: fill the other bank while reading the front one;
        // include writes to the nonexistent block 15.
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < PX; p++)
                step(1, b, p, DW'($urandom), 0, 0, (p % 3) == 0, 1);
        for (int i = 0; i < 8; i++) step(1, NB, i, DW'($urandom), 0, 0, 1, 1);
        step(0, 0, 0, '0, 0, 1, 0, 1);

        // Swap rules.
        step(0, 0, 0, '0, 0, 1, 0, 1);          // SOF, nothing armed
        step(0, 0, 0, '0, 1, 1, 0, 1);          // frame_done with SOF: arm only
        step(0, 0, 0, '0, 0, 0, 1, 1);
        step(0, 0, 0, '0, 0, 1, 0, 1);          // swap now
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, 0, 1, 1);

        // Gating: disabled SOF/EOC with an armed swap change nothing.
        step(0, 0, 0, '0, 1, 0, 0, 1);
        step(0, 0, 0, '0, 0, 1, 0, 0);
        step(0, 0, 0, '0, 0, 0, 1, 0);
        step(0, 0, 0, '0, 0, 1, 1, 0);
        step(0, 0, 0, '0, 0, 0, 1, 1);
        step(0, 0, 0, '0, 0, 1, 1, 1);          // SOF and EOC: SOF wins, swap
        step(0, 0, 0, '0, 0, 0, 1, 1);

        // Overrun: two frame_done without SOF, then sticky.
        step(0, 0, 0, '0, 1, 0, 0, 1);
        step(0, 0, 0, '0, 1, 0, 0, 1);
        step(0, 0, 0, '0, 0, 1, 0, 1);
        idle(); idle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, NB), $urandom_range(0, PX - 1),
                 DW'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0);

        // Reset mid-frame with a swap armed and a read in flight.
        step(0, 0, 0, '0, 1, 0, 0, 1);
        step(0, 0, 0, '0, 0, 0, 1, 1);
        nrst = 0;
        model_reset();
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        nrst = 1;
        step(0, 0, 0, '0, 0, 1, 0, 1);          // armed swap was lost
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, 0, 1, 1);

        for (int i = 0; i < 10 && q.size() != 0; i++) idle();
        if (q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d reads outstanding expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_pingpong_array.md
# ram_pingpong_array

Parametrised successor to the fixed 15-block framebuffer RAM array: `NUM_BLOCKS` independent pixel RAMs, each `DATA_WIDTH` wide and `PIXELS` deep per bank. Each RAM is double-buffered, so the pixel writer fills a back bank while the LED driver side reads the front bank column by column. Banks swap only on a driver start-of-frame after the writer has declared the back bank complete. The block sits between the pixel-stream writer and the per-block framebuffer/poker formatting logic.

## Interface
- `NUM_BLOCKS`, 15: number of independent block RAMs and output channels; range 1 to 32.
- `PIXELS`, 128: pixels per block per bank; power of two, at least 2.
- `DATA_WIDTH`, 24: pixel width in bits.

- `clk` in 1: system clock.
- `nrst` in 1: asynchronous, active-low reset.
- `clk_enable` in 1: qualifies `SOF` and `EOC`; while low, the read side holds state.
- `block_number` in `$clog2(NUM_BLOCKS)` (minimum 1): target block of a write.
- `pixel_number` in `$clog2(PIXELS)`: target pixel address of a write.
- `ram_data` in `DATA_WIDTH`: write data.
- `block_write_enable` in 1: write strobe.
- `frame_done` in 1: single-cycle pulse; the back bank is complete.
- `SOF` in 1: driver start of frame.
- `EOC` in 1: driver end of column; advance the read address.
- `data_out` out `[NUM_BLOCKS-1:0][DATA_WIDTH-1:0]`: registered read data, one word per block.
- `data_valid` out 1: one-cycle pulse marking new `data_out`.
- `drivers_SOF` out 1: one-cycle pulse, coincident with `data_valid`, for SOF-initiated reads.
- `front_sel` out 1: index of the bank being displayed.
- `overrun` out 1: sticky; `frame_done` arrived while a swap was already pending.

## Operation
- **Storage.** Each block has one simple dual-port RAM, `2*PIXELS` deep. Address is `{bank, pixel}`.
- **Writes.**
  - A write happens when `block_write_enable` is high. It targets bank `~front_sel` of block `block_number` at address `pixel_number`.
  - Writes with `block_number >= NUM_BLOCKS` are dropped silently.
  - Writes are not gated by `clk_enable`.
- **Swap FSM**, states IDLE and PENDING:
  - IDLE, `frame_done`: go to PENDING.
  - PENDING, `frame_done`: set `overrun`; stay in PENDING.
  - PENDING, `SOF && clk_enable`: toggle `front_sel`; go to IDLE.
  - `frame_done` and a qualified `SOF` in the same cycle while IDLE: go to PENDING with no swap. The swap happens at the next `SOF`.
  - A write in the same cycle as a swap uses the pre-swap `front_sel`, i.e. the old back bank.
- **Read address** (`rd_addr`, `$clog2(PIXELS)` bits):
  - Qualified `SOF`: `rd_addr` <= 0, using the post-swap bank.
  - Qualified `EOC`: `rd_addr` <= `rd_addr+1`, wrapping from `PIXELS-1` to 0.
  - `SOF` and `EOC` together: `SOF` wins.
  - Each qualified event issues one read to all blocks in parallel.
- **`overrun`** clears only on reset.

## Timing
- Reset values:
  - `front_sel`=0, FSM=IDLE, `rd_addr`=0.
  - `data_out`=0 on all channels.
  - `data_valid`=0, `drivers_SOF`=0, `overrun`=0.
  - RAM contents undefined.
- Read pipeline, for a qualified event sampled at edge k:
  - `rd_addr` and bank update at edge k.
  - RAM q is registered at edge k+1.
  - `data_out`, `data_valid` and (for `SOF`) `drivers_SOF` update at edge k+2.
  - `data_valid` and `drivers_SOF` stay high for one cycle.
- A second event at edge k+1 yields `data_valid` at both k+2 and k+3, so back-to-back events are supported.
- Write-to-read: a word written at edge w to the back bank is readable after the swap. A same-address read/write in the same cycle is impossible because the banks differ.
- `front_sel` changes at the edge that samples the swapping `SOF`.
- Reset asserted mid-frame returns every register to its reset value immediately. A pending swap is lost.

## Configuration
- `RAM_PINGPONG_DOUBLE_BUFFER_EN` defined:
  - Behaviour as above; RAM depth `2*PIXELS`.
- Undefined:
  - Single bank; RAM depth `PIXELS`; writes go directly to the displayed bank.
  - `front_sel` tied to 0; `frame_done` ignored; `overrun` tied to 0; no swap FSM.
  - Read pipeline and latency unchanged.

## Test plan
- **Basic read-out.** Write pixel p of block b with `{b,p}` patterns into bank 1, pulse `frame_done`, then `SOF` -> `front_sel`=1. At k+2, `data_valid`=`drivers_SOF`=1 and `data_out[b]`={b,0}. Each later `EOC` yields {b,p} in order.
- **Wrap-around.** Issue `PIXELS` `EOC`s after `SOF` -> the last word is pixel `PIXELS-1`, the next is pixel 0. `drivers_SOF` stays 0 for `EOC` reads.
- **Swap rules.**
  - `SOF` with no pending frame -> `front_sel` unchanged.
  - `frame_done` and `SOF` in the same cycle -> no swap; the next `SOF` swaps.
  - Two `frame_done` without `SOF` -> `overrun`=1 and sticky.
- **Back-bank isolation.** Overwrite the back bank while reading the front bank -> `data_out` shows only front-bank data until the swap. An out-of-range `block_number`=15 with `NUM_BLOCKS`=15 -> no RAM changes.
- **Gating.** `clk_enable`=0 during `SOF`/`EOC` -> no address change, no `data_valid`, no swap. `SOF` and `EOC` together -> `rd_addr`=0.
- **Reset.** Assert `nrst` mid-frame with a swap pending -> all outputs 0 immediately; after release, `SOF` does not swap.
